// File: rtl/psram_bus_sequencer_if.sv
// System-bus side of the PSRAM sequencer: one request in flight, completion pulse on bus_ready.
// The master holds every request field stable until it sees bus_ready.
interface psram_bus_sequencer_if;
   logic        bus_valid;
   logic        bus_we;
   logic [23:0] bus_addr;
   logic [1:0]  bus_size;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_size, bus_wdata,
      input  bus_rdata, bus_ready
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_size, bus_wdata,
      output bus_rdata, bus_ready
   );
endinterface

// File: rtl/psram_bus_sequencer.sv
// Front end for the QSPI/QPI PSRAM controller: runs the power-up command sequence, then turns
// single bus requests into QPI quad-read (EBh) / quad-write (38h) controller transactions.
module psram_bus_sequencer #(
   parameter int INIT_DELAY = 15000,
   parameter int RD_WAIT    = 6,
   parameter int GAP_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   psram_bus_sequencer_if.slave        bus,
   output logic                        init_done,
   output logic [23:0]                 psram_addr,
   output logic [31:0]                 psram_wdata,
   input  logic [31:0]                 psram_rdata,
   output logic [2:0]                  psram_size,
   output logic                        psram_start,
   input  logic                        psram_done,
   output logic [3:0]                  psram_wait,
   output logic [7:0]                  psram_cmd,
   output logic                        psram_rd_wr,
   output logic                        psram_qspi,
   output logic                        psram_qpi,
   output logic                        psram_short
);

   typedef enum logic [2:0] {
      S_POR_WAIT,
      S_INIT_CMD,
      S_INIT_XFER,
      S_INIT_GAP,
      S_IDLE,
      S_XFER,
      S_GAP
   } state_t;

   localparam logic [31:0] DLY_LAST = 32'(INIT_DELAY - 1);
   localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
   localparam logic [7:0]  CMD_RD   = 8'hEB;
   localparam logic [7:0]  CMD_WR   = 8'h38;

   state_t      r_state;
   logic [31:0] r_cnt;
   logic [1:0]  r_idx;
   logic        r_init_done;
   logic [31:0] r_rdata;
   logic        r_ready;
   logic [23:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_size;
   logic        r_start;
   logic [3:0]  r_wait;
   logic [7:0]  r_cmd;
   logic        r_rd_wr;
   logic        r_qpi;
   logic        r_short;

   logic [2:0]  w_wr_size;
   logic [31:0] w_wr_data;

   // Power-up order: reset-enable, reset, enter-QPI.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h66;
         2'd1:    return 8'h99;
         default: return 8'h35;
      endcase
   endfunction

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_wr_size = 3'd4;
      case (bus.bus_size)
         2'd0:    w_wr_size = 3'd1;
         2'd1:    w_wr_size = 3'd2;
         default: w_wr_size = 3'd4;
      endcase
   end

   // Lane-replicated bus data is shifted so the addressed byte lands in bits [7:0].
   assign w_wr_data = bus.bus_wdata >> {bus.bus_addr[1:0], 3'b000};

   // NOTE: state and outputs update with non-blocking assignments only; start and ready
   // default low each cycle so they can only ever be single-cycle pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_POR_WAIT;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_init_done <= 1'b0;
         r_rdata     <= '0;
         r_ready     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_size      <= 3'd4;
         r_start     <= 1'b0;
         r_wait      <= '0;
         r_cmd       <= '0;
         r_rd_wr     <= 1'b0;
         r_qpi       <= 1'b0;
         r_short     <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_ready <= 1'b0;
         case (r_state)
            S_POR_WAIT: begin
               if (r_cnt == DLY_LAST) begin
                  r_cnt   <= '0;
                  r_start <= 1'b1;
                  r_cmd   <= init_cmd(r_idx);
                  r_short <= 1'b1;
                  r_qpi   <= 1'b0;
                  r_rd_wr <= 1'b0;
                  r_wait  <= '0;
                  r_state <= S_INIT_CMD;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_INIT_CMD: r_state <= S_INIT_XFER;
            S_INIT_XFER: begin
               if (psram_done) begin
                  r_cnt   <= '0;
                  r_state <= S_INIT_GAP;
               end
            end
            S_INIT_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_cnt <= '0;
                  r_idx <= r_idx + 2'd1;
                  if (r_idx == 2'd2) begin
                     r_init_done <= 1'b1;
                     r_qpi       <= 1'b1;
                     r_state     <= S_IDLE;
                  end else begin
                     r_start <= 1'b1;
                     r_cmd   <= init_cmd(r_idx + 2'd1);
                     r_state <= S_INIT_CMD;
                  end
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_IDLE: begin
               if (bus.bus_valid && r_init_done) begin
                  r_start <= 1'b1;
                  r_short <= 1'b0;
                  r_state <= S_XFER;
                  if (bus.bus_we) begin
                     r_cmd   <= CMD_WR;
                     r_rd_wr <= 1'b0;
                     r_wait  <= '0;
                     r_addr  <= bus.bus_addr;
                     r_size  <= w_wr_size;
                     r_wdata <= w_wr_data;
                  end else begin
                     r_cmd   <= CMD_RD;
                     r_rd_wr <= 1'b1;
                     r_wait  <= 4'(RD_WAIT);
                     r_addr  <= {bus.bus_addr[23:2], 2'b00};
                     r_size  <= 3'd4;
                  end
               end
            end
            S_XFER: begin
               // Only the first done cycle counts; a second one lands in GAP and is ignored.
               if (psram_done) begin
                  if (r_rd_wr) r_rdata <= psram_rdata;
                  r_ready <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            default: r_state <= S_POR_WAIT;
         endcase
      end
   end

   assign bus.bus_rdata = r_rdata;
   assign bus.bus_ready = r_ready;
   assign init_done     = r_init_done;
   assign psram_addr    = r_addr;
   assign psram_wdata   = r_wdata;
   assign psram_size    = r_size;
   assign psram_start   = r_start;
   assign psram_wait    = r_wait;
   assign psram_cmd     = r_cmd;
   assign psram_rd_wr   = r_rd_wr;
   assign psram_qspi    = 1'b0;
   assign psram_qpi     = r_qpi;
   assign psram_short   = r_short;

endmodule

// File: tb/tb_psram_bus_sequencer.sv
// Directed bench for psram_bus_sequencer: init sequence, held early request, read/write mapping,
// done held two cycles, GAP spacing, valid dropped mid-transfer and reset during a transfer.
module tb_psram_bus_sequencer;
   localparam int INIT_DELAY = 10;
   localparam int RD_WAIT    = 6;
   localparam int GAP_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_done;
   logic [23:0] psram_addr;
   logic [31:0] psram_wdata;
   logic [31:0] psram_rdata;
   logic [2:0]  psram_size;
   logic        psram_start;
   logic        psram_done;
   logic [3:0]  psram_wait;
   logic [7:0]  psram_cmd;
   logic        psram_rd_wr;
   logic        psram_qspi;
   logic        psram_qpi;
   logic        psram_short;

   psram_bus_sequencer_if bus_if ();

   psram_bus_sequencer #(
      .INIT_DELAY (INIT_DELAY),
      .RD_WAIT    (RD_WAIT),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_if),
      .init_done   (init_done),
      .psram_addr  (psram_addr),
      .psram_wdata (psram_wdata),
      .psram_rdata (psram_rdata),
      .psram_size  (psram_size),
      .psram_start (psram_start),
      .psram_done  (psram_done),
      .psram_wait  (psram_wait),
      .psram_cmd   (psram_cmd),
      .psram_rd_wr (psram_rd_wr),
      .psram_qspi  (psram_qspi),
      .psram_qpi   (psram_qpi),
      .psram_short (psram_short)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Controller model log: one entry per observed start pulse.
   int          start_cnt = 0;
   int          start_cyc [32];
   logic [23:0] log_addr  [32];
   logic [31:0] log_wdata [32];
   logic [17:0] log_ctl   [32];
   int          done_len   = 2;
   logic [31:0] model_rdata = 32'h0;

   int ready_cnt = 0;
   int ready_cyc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {short, qpi, rd_wr, wait, size, cmd}
   function automatic logic [17:0] ctl(input logic s, input logic q, input logic rw,
                                      input logic [3:0] w, input logic [2:0] sz,
                                      input logic [7:0] c);
      return {s, q, rw, w, sz, c};
   endfunction

   initial begin
      psram_done  = 1'b0;
      psram_rdata = 32'h0;
      forever begin
         @(posedge clk); #1;
         if (psram_start === 1'b1) begin
            start_cyc[start_cnt] = cyc;
            log_addr[start_cnt]  = psram_addr;
            log_wdata[start_cnt] = psram_wdata;
            log_ctl[start_cnt]   = {psram_short, psram_qpi, psram_rd_wr, psram_wait,
                                    psram_size, psram_cmd};
            start_cnt++;
            repeat (3) @(posedge clk);
            #1 psram_done = 1'b1;
            psram_rdata = model_rdata;
            repeat (done_len) @(posedge clk);
            #1 psram_done = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (bus_if.bus_ready === 1'b1) begin
            ready_cnt++;
            ready_cyc = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic wait_init(output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk); #1;
         if (init_done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic wait_ready(output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk); #1;
         if (bus_if.bus_ready === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic wait_starts(input int n, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk); #1;
         if (start_cnt >= n) seen = 1'b1;
      end
   endtask

   task automatic check_init(input int base, input int rel);
      check("init_delay", 64'(start_cyc[base] - rel), 64'(INIT_DELAY));
      check("init_cmd0", log_ctl[base],     ctl(1'b1, 1'b0, 1'b0, 4'd0, 3'd4, 8'h66));
      check("init_cmd1", log_ctl[base + 1], ctl(1'b1, 1'b0, 1'b0, 4'd0, 3'd4, 8'h99));
      check("init_cmd2", log_ctl[base + 2], ctl(1'b1, 1'b0, 1'b0, 4'd0, 3'd4, 8'h35));
   endtask

   initial begin
      logic seen;
      int   rel;
      int   r1;

      rst_n             = 1'b0;
      bus_if.bus_valid  = 1'b0;
      bus_if.bus_we     = 1'b0;
      bus_if.bus_addr   = '0;
      bus_if.bus_size   = '0;
      bus_if.bus_wdata  = '0;
      repeat (3) @(posedge clk); #1;
      check("rst_size", psram_size, 3'd4);
      check("rst_outs", {init_done, psram_start, bus_if.bus_ready, psram_qpi, psram_short,
                         psram_rd_wr, psram_qspi, psram_cmd, psram_wait}, '0);
      check("rst_rdata", bus_if.bus_rdata, 32'h0);

      // Read request posted before init finishes; it must wait.
      model_rdata      = 32'h44332211;
      bus_if.bus_valid = 1'b1;
      bus_if.bus_we    = 1'b0;
      bus_if.bus_addr  = 24'h000103;
      bus_if.bus_size  = 2'd2;
      @(negedge clk);
      rst_n = 1'b1;
      rel   = cyc;
      wait_init(seen);
      check("init_seen", seen, 1'b1);
      check("no_early_start", 64'(start_cnt), 64'd3);
      check("qpi_after_init", psram_qpi, 1'b1);
      check_init(0, rel);

      wait_ready(seen);
      check("rd_ready_seen", seen, 1'b1);
      check("rd_rdata", bus_if.bus_rdata, 32'h44332211);
      check("rd_addr", log_addr[3], 24'h000100);
      check("rd_ctl", log_ctl[3], ctl(1'b0, 1'b1, 1'b1, 4'd6, 3'd4, 8'hEB));
      r1 = cyc;

      // Byte write posted immediately after completion; GAP spaces the next start.
      bus_if.bus_we    = 1'b1;
      bus_if.bus_addr  = 24'h000002;
      bus_if.bus_size  = 2'd0;
      bus_if.bus_wdata = 32'hAAAAAAAA;
      wait_ready(seen);
      bus_if.bus_valid = 1'b0;
      check("wb_ready_seen", seen, 1'b1);
      check("wb_gap", 64'(start_cyc[4] - r1), 64'(GAP_CYCLES + 1));
      check("wb_addr", log_addr[4], 24'h000002);
      check("wb_wdata", log_wdata[4], 32'h0000AAAA);
      check("wb_ctl", log_ctl[4], ctl(1'b0, 1'b1, 1'b0, 4'd0, 3'd1, 8'h38));
      check("rdata_held", bus_if.bus_rdata, 32'h44332211);
      repeat (8) @(posedge clk); #1;
      check("served_once", 64'(start_cnt), 64'd5);
      check("single_ready", 64'(ready_cnt), 64'd2);

      // Misaligned half write, issued unsplit.
      bus_if.bus_valid = 1'b1;
      bus_if.bus_addr  = 24'h000101;
      bus_if.bus_size  = 2'd1;
      bus_if.bus_wdata = 32'hBBBBBBBB;
      wait_ready(seen);
      bus_if.bus_valid = 1'b0;
      check("wh_addr", log_addr[5], 24'h000101);
      check("wh_wdata", log_wdata[5], 32'h00BBBBBB);
      check("wh_size", log_ctl[5][10:8], 3'd2);
      @(posedge clk);

      // bus_size=3 behaves as a word write.
      bus_if.bus_valid = 1'b1;
      bus_if.bus_addr  = 24'h000004;
      bus_if.bus_size  = 2'd3;
      bus_if.bus_wdata = 32'h12345678;
      wait_ready(seen);
      bus_if.bus_valid = 1'b0;
      check("ww_wdata", log_wdata[6], 32'h12345678);
      check("ww_ctl", log_ctl[6], ctl(1'b0, 1'b1, 1'b0, 4'd0, 3'd4, 8'h38));
      @(posedge clk);

      // Read whose bus_valid drops right after the start pulse.
      done_len         = 1;
      model_rdata      = 32'hCAFEF00D;
      bus_if.bus_valid = 1'b1;
      bus_if.bus_we    = 1'b0;
      bus_if.bus_addr  = 24'h00ABCF;
      wait_starts(8, seen);
      bus_if.bus_valid = 1'b0;
      check("drop_start_seen", seen, 1'b1);
      wait_ready(seen);
      check("drop_ready_seen", seen, 1'b1);
      check("drop_rdata", bus_if.bus_rdata, 32'hCAFEF00D);
      check("drop_addr", log_addr[7], 24'h00ABCC);
      repeat (6) @(posedge clk); #1;
      check("ready_count", 64'(ready_cnt), 64'd5);

      // Reset asserted while a read is in XFER.
      done_len         = 2;
      bus_if.bus_valid = 1'b1;
      bus_if.bus_addr  = 24'h000010;
      wait_starts(9, seen);
      bus_if.bus_valid = 1'b0;
      check("rst_xfer_start_seen", seen, 1'b1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_size", psram_size, 3'd4);
      check("midrst_outs", {init_done, psram_start, bus_if.bus_ready, psram_qpi, psram_short,
                            psram_rd_wr, psram_cmd, psram_wait}, '0);
      check("midrst_rdata", bus_if.bus_rdata, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rel   = cyc;
      wait_init(seen);
      check("reinit_seen", seen, 1'b1);
      check("reinit_starts", 64'(start_cnt), 64'd12);
      check_init(9, rel);
      check("no_ready_after_rst", 64'(ready_cnt), 64'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
